// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: active-low a..g segment
// patterns (bit6=a .. bit0=g), capture FSM state encoding and anode constants.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [7:0] ANODE_NONE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational inverse of the hex display encoder: active-low segment
// pattern in, nibble plus blank / error classification out.
module seg7_pattern_decoder
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       blank,
    output logic       err
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        value = 4'h0;
        blank = 1'b0;
        err   = 1'b0;
        case (pattern)
            SEG_0:     value = 4'h0;
            SEG_1:     value = 4'h1;
            SEG_2:     value = 4'h2;
            SEG_3:     value = 4'h3;
            SEG_4:     value = 4'h4;
            SEG_5:     value = 4'h5;
            SEG_6:     value = 4'h6;
            SEG_7:     value = 4'h7;
            SEG_8:     value = 4'h8;
            SEG_9:     value = 4'h9;
            SEG_A:     value = 4'hA;
            SEG_B:     value = 4'hB;
            SEG_C:     value = 4'hC;
            SEG_D:     value = 4'hD;
            SEG_E:     value = 4'hE;
            SEG_F:     value = 4'hF;
            SEG_BLANK: blank = 1'b1;
            default:   err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Reconstructs the hex value on each digit of a scanned 7-segment display by
// sampling each anode dwell once its anode/segment lines have settled.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clock_100Mhz,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   Anode_Activate,
    input  logic [6:0]              LED_out,
    output logic [4*NUM_DIGITS-1:0] digit_value,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    anode_err
);

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0] an_s1, an_s2, an_lat;
    logic [6:0]            seg_s1, seg_s2, seg_lat;
    logic [7:0]            cnt;
    logic [NUM_DIGITS-1:0] seen;
    state_t                state, state_next;

    logic       in_idle, match, expired, lat_onehot, lat_idle;
    logic       do_latch, do_count, do_write, do_anode_err;
    logic [2:0] idx;
    logic [3:0] dec_value;
    logic       dec_blank, dec_err;

    // Two-flop synchronisers; the idle level of both buses is all ones.
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            an_s1  <= ANODE_NONE;
            an_s2  <= ANODE_NONE;
            seg_s1 <= SEG_BLANK;
            seg_s2 <= SEG_BLANK;
        end else begin
            // NOTE: non-blocking assignments make s2 take the old s1, giving a
            // real two-stage chain regardless of statement order.
            an_s1  <= Anode_Activate;
            an_s2  <= an_s1;
            seg_s1 <= LED_out;
            seg_s2 <= seg_s1;
        end
    end

    assign in_idle    = (an_s2 == ANODE_NONE);
    assign match      = (an_s2 == an_lat) && (seg_s2 == seg_lat);
    assign expired    = (cnt == CNT_LAST);
    assign lat_onehot = $onehot(~an_lat);
    assign lat_idle   = (an_lat == ANODE_NONE);

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!in_idle) state_next = SETTLE;
            SETTLE: begin
                if (!match) begin
                    if (in_idle) state_next = IDLE;
                end else if (expired) begin
                    state_next = lat_idle ? IDLE : HOLD;
                end
            end
            HOLD:    if (!match) state_next = in_idle ? IDLE : SETTLE;
            default: state_next = IDLE;
        endcase
    end

    // A change on the lines always wins over a simultaneous counter expiry.
    always_comb begin
        do_latch     = 1'b0;
        do_count     = 1'b0;
        do_write     = 1'b0;
        do_anode_err = 1'b0;
        case (state)
            IDLE:    do_latch = !in_idle;
            SETTLE: begin
                if (!match) begin
                    do_latch = !in_idle;
                end else if (expired) begin
                    do_write     = lat_onehot;
                    do_anode_err = !lat_onehot && !lat_idle;
                end else begin
                    do_count = 1'b1;
                end
            end
            HOLD:    do_latch = !match && !in_idle;
            default: ;
        endcase
    end

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_lat[i]) idx = 3'(i);
        end
    end

    seg7_pattern_decoder u_decoder (
        .pattern (seg_lat),
        .value   (dec_value),
        .blank   (dec_blank),
        .err     (dec_err)
    );

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            an_lat      <= ANODE_NONE;
            seg_lat     <= SEG_BLANK;
            cnt         <= 8'd0;
            seen        <= '0;
            digit_value <= '0;
            digit_blank <= '1;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            anode_err   <= do_anode_err;
            if (do_latch) begin
                an_lat  <= an_s2;
                seg_lat <= seg_s2;
                cnt     <= 8'd0;
            end else if (do_count) begin
                cnt <= cnt + 8'd1;
            end
            if (do_write) begin
                digit_value[4*idx +: 4] <= dec_value;
                digit_blank[idx]        <= dec_blank;
                digit_err[idx]          <= dec_err;
                if ((seen | (8'h01 << idx)) == 8'hFF) begin
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seen | (8'h01 << idx);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with SETTLE_CYCLES=4: latency, full
// frames, glitch rejection, error classification and mid-frame reset.
module tb_seg7_scan_capture;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk;
    logic        reset;
    logic [7:0]  an;
    logic [6:0]  led;
    logic [31:0] digit_value;
    logic [7:0]  digit_blank;
    logic [7:0]  digit_err;
    logic        frame_valid;
    logic        anode_err;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0;
    int aerr_cnt = 0;

    seg7_scan_capture #(.SETTLE_CYCLES(4)) dut (
        .clock_100Mhz   (clk),
        .reset          (reset),
        .Anode_Activate (an),
        .LED_out        (led),
        .digit_value    (digit_value),
        .digit_blank    (digit_blank),
        .digit_err      (digit_err),
        .frame_valid    (frame_valid),
        .anode_err      (anode_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) frame_cnt++;
        if (anode_err === 1'b1) aerr_cnt++;
    end

    // Drives the lines, holds them for n clocks, returns 1 time unit after an edge.
    task automatic drive(input logic [7:0] a, input logic [6:0] s, input int n);
        an  = a;
        led = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        an    = 8'b11111110;
        led   = 7'b0000000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (digit_value !== 32'h0) begin
            errors++; $display("FAIL reset_value: got %h expected %h", digit_value, 32'h0);
        end
        checks++;
        if (digit_blank !== 8'hFF) begin
            errors++; $display("FAIL reset_blank: got %h expected %h", digit_blank, 8'hFF);
        end
        checks++;
        if (digit_err !== 8'h00) begin
            errors++; $display("FAIL reset_err: got %h expected %h", digit_err, 8'h00);
        end
        checks++;
        if ({frame_valid, anode_err} !== 2'b00) begin
            errors++; $display("FAIL reset_pulses: got %b expected %b", {frame_valid, anode_err}, 2'b00);
        end
        an    = 8'hFF;
        led   = 7'b1111111;
        reset = 1'b1;
        drive(8'hFF, 7'b1111111, 8);
        checks++;
        if (digit_value !== 32'h0 || digit_blank !== 8'hFF) begin
            errors++; $display("FAIL post_reset_idle: got %h/%h expected %h/%h",
                               digit_value, digit_blank, 32'h0, 8'hFF);
        end
        checks++;
        if (frame_cnt != 0 || aerr_cnt != 0) begin
            errors++; $display("FAIL post_reset_pulses: got %0d/%0d expected 0/0", frame_cnt, aerr_cnt);
        end
    endtask

    task automatic test_single_digit();
        int f0;
        f0 = frame_cnt;
        drive(8'b11111011, 7'b0010010, 6);
        checks++;
        if (digit_value[11:8] !== 4'h0) begin
            errors++; $display("FAIL single_early: got %h expected %h", digit_value[11:8], 4'h0);
        end
        drive(8'b11111011, 7'b0010010, 1);
        checks++;
        if (digit_value[11:8] !== 4'h2) begin
            errors++; $display("FAIL single_latency: got %h expected %h", digit_value[11:8], 4'h2);
        end
        drive(8'b11111011, 7'b0010010, 3);
        checks++;
        if (digit_blank !== 8'hFB) begin
            errors++; $display("FAIL single_blank: got %h expected %h", digit_blank, 8'hFB);
        end
        checks++;
        if (frame_cnt != f0) begin
            errors++; $display("FAIL single_no_frame: got %0d expected %0d", frame_cnt, f0);
        end
        drive(8'hFF, 7'b1111111, 5);
    endtask

    task automatic test_full_frame();
        int f0;
        f0 = frame_cnt;
        for (int pass = 0; pass < 2; pass++) begin
            for (int d = 0; d < 8; d++) begin
                drive(~(8'h01 << d), SEG_TAB[d], 20);
                if (d == 6) begin
                    checks++;
                    if (frame_cnt != f0 + pass) begin
                        errors++; $display("FAIL frame_early: got %0d expected %0d", frame_cnt, f0 + pass);
                    end
                end
                if (d == 7) begin
                    checks++;
                    if (frame_cnt != f0 + pass + 1) begin
                        errors++; $display("FAIL frame_pulse: got %0d expected %0d", frame_cnt, f0 + pass + 1);
                    end
                end
            end
        end
        drive(8'hFF, 7'b1111111, 5);
        checks++;
        if (digit_value !== 32'h76543210) begin
            errors++; $display("FAIL frame_value: got %h expected %h", digit_value, 32'h76543210);
        end
        checks++;
        if (digit_blank !== 8'h00 || digit_err !== 8'h00) begin
            errors++; $display("FAIL frame_flags: got %h/%h expected 00/00", digit_blank, digit_err);
        end
    endtask

    task automatic test_glitch();
        drive(8'hFE, SEG_TAB[8], 20);
        checks++;
        if (digit_value[3:0] !== 4'h8) begin
            errors++; $display("FAIL glitch_setup: got %h expected %h", digit_value[3:0], 4'h8);
        end
        for (int k = 0; k < 10; k++) begin
            drive(8'hFE, (k % 2 == 1) ? SEG_TAB[1] : SEG_TAB[0], 2);
        end
        checks++;
        if (digit_value[3:0] !== 4'h8) begin
            errors++; $display("FAIL glitch_reject: got %h expected %h", digit_value[3:0], 4'h8);
        end
        drive(8'hFE, SEG_TAB[1], 10);
        checks++;
        if (digit_value[3:0] !== 4'h1 || digit_err[0] !== 1'b0) begin
            errors++; $display("FAIL glitch_settle: got %h/%b expected 1/0", digit_value[3:0], digit_err[0]);
        end
        drive(8'hFF, 7'b1111111, 5);
    endtask

    task automatic test_anode_err();
        int          a0;
        logic [31:0] v0;
        a0 = aerr_cnt;
        v0 = 32'h76543211;
        drive(8'b11110011, SEG_TAB[3], 20);
        checks++;
        if (aerr_cnt != a0 + 1) begin
            errors++; $display("FAIL anode_err_pulse: got %0d expected %0d", aerr_cnt, a0 + 1);
        end
        checks++;
        if (digit_value !== v0) begin
            errors++; $display("FAIL anode_err_nowrite: got %h expected %h", digit_value, v0);
        end
        drive(8'hFF, 7'b1111111, 5);
        checks++;
        if (aerr_cnt != a0 + 1) begin
            errors++; $display("FAIL anode_err_single: got %0d expected %0d", aerr_cnt, a0 + 1);
        end
    endtask

    task automatic test_digit_err();
        drive(8'hDF, 7'b1110111, 10);
        checks++;
        if (digit_value[23:20] !== 4'h0) begin
            errors++; $display("FAIL derr_value: got %h expected %h", digit_value[23:20], 4'h0);
        end
        checks++;
        if (digit_err !== 8'h20) begin
            errors++; $display("FAIL derr_flag: got %h expected %h", digit_err, 8'h20);
        end
        checks++;
        if (digit_blank !== 8'h00) begin
            errors++; $display("FAIL derr_blank: got %h expected %h", digit_blank, 8'h00);
        end
        drive(8'hDF, 7'b1111111, 10);
        checks++;
        if (digit_blank !== 8'h20) begin
            errors++; $display("FAIL blank_flag: got %h expected %h", digit_blank, 8'h20);
        end
        checks++;
        if (digit_err !== 8'h00) begin
            errors++; $display("FAIL blank_err: got %h expected %h", digit_err, 8'h00);
        end
        checks++;
        if (digit_value[23:20] !== 4'h0) begin
            errors++; $display("FAIL blank_value: got %h expected %h", digit_value[23:20], 4'h0);
        end
        drive(8'hFF, 7'b1111111, 5);
    endtask

    task automatic test_mid_reset();
        int order [8] = '{4, 5, 6, 7, 0, 1, 2, 3};
        int f0;
        for (int d = 0; d < 4; d++) drive(~(8'h01 << d), SEG_TAB[8 + d], 20);
        checks++;
        if (digit_value[15:0] !== 16'hBA98) begin
            errors++; $display("FAIL partial_frame: got %h expected %h", digit_value[15:0], 16'hBA98);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (digit_value !== 32'h0 || digit_blank !== 8'hFF || digit_err !== 8'h00) begin
            errors++; $display("FAIL mid_reset_outputs: got %h/%h/%h expected 0/ff/00",
                               digit_value, digit_blank, digit_err);
        end
        an  = 8'hFF;
        led = 7'b1111111;
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(8'hFF, 7'b1111111, 3);
        f0 = frame_cnt;
        for (int j = 0; j < 8; j++) begin
            drive(~(8'h01 << order[j]), SEG_TAB[15 - order[j]], 20);
            if (j == 6) begin
                checks++;
                if (frame_cnt != f0) begin
                    errors++; $display("FAIL mid_reset_early_frame: got %0d expected %0d", frame_cnt, f0);
                end
            end
            if (j == 7) begin
                checks++;
                if (frame_cnt != f0 + 1) begin
                    errors++; $display("FAIL mid_reset_frame: got %0d expected %0d", frame_cnt, f0 + 1);
                end
            end
        end
        drive(8'hFF, 7'b1111111, 5);
        checks++;
        if (digit_value !== 32'h89ABCDEF) begin
            errors++; $display("FAIL mid_reset_value: got %h expected %h", digit_value, 32'h89ABCDEF);
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_full_frame();
        test_glitch();
        test_anode_err();
        test_digit_err();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receiver end of the multiplexed 7-segment display interface. Monitors the scanned anode and segment lines produced by the ALU/decoder display driver and reconstructs the hex value shown on each of the 8 digits.
- Used for on-board self-check and for bench scoreboarding of the display path: display output -> captured nibbles -> compare against ALU result.

Parameters:
- SETTLE_CYCLES, 4: consecutive stable cycles required on anode+segment lines before a digit is sampled (range 1..255).
- NUM_DIGITS, 8: number of anodes monitored; fixed at 8 for this design.

Ports:
- clock_100Mhz  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- Anode_Activate  input  8  active-low one-hot digit select from the display driver.
- LED_out  input  7  active-low segments; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- digit_value  output  32  captured nibble per digit; digit i at bits [4i+3:4i].
- digit_blank  output  8  1 = digit i last sampled with all segments off.
- digit_err  output  8  1 = digit i last sampled with a non-hex, non-blank pattern.
- frame_valid  output  1  one-cycle pulse when all 8 digits have been captured since the last pulse.
- anode_err  output  1  one-cycle pulse on a stable multi-hot anode pattern.

Behaviour:
- Reset (async, reset=0): digit_value=0, digit_blank=8'hFF, digit_err=0, frame_valid=0, anode_err=0, seen mask=0, state=IDLE, sync flops=all ones (inactive).
- Input sync: Anode_Activate and LED_out each pass through 2-flop synchronisers. All logic below uses the synced values.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - Synced anode is valid one-hot-low -> load settle counter=0, latch anode+segments, go SETTLE.
  - All ones -> stay IDLE.
  - Multi-hot -> handled in SETTLE (see below).
  - IDLE also enters SETTLE on any non-all-ones pattern.
- SETTLE:
  - Each cycle, compare current anode+segments against the latched copy.
  - Mismatch -> relatch and reset counter to 0 (restart).
  - Match -> counter+1. When counter reaches SETTLE_CYCLES-1 with a match:
    - Valid one-hot: write the decode result into slot i, set seen[i], go HOLD.
    - Multi-hot: pulse anode_err, go HOLD with no write.
    - All ones: go IDLE.
- HOLD:
  - Stay while anode+segments equal the latched copy.
  - Any change -> IDLE-equivalent handling on the same cycle: relatch and enter SETTLE, or go IDLE if all ones.
  - Each digit is therefore captured at most once per dwell.
- Decode (combinational), active-low a..g patterns:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - 1111111 -> blank=1, value=0.
  - Any other pattern -> err=1, value=0.
  - On each write, all three fields for slot i (value, blank, err) are updated together.
- Frame:
  - When the write makes seen==8'hFF, assert frame_valid for exactly 1 cycle and clear seen in the same cycle.
  - Re-capture of an already-seen digit does not advance seen.
- Latency: first LED change to updated digit_value = 2 (sync) + SETTLE_CYCLES + 1 cycles.
- Simultaneous anode change and counter expiry: the change wins; counter restarts and no write occurs.
- Reset mid-frame: all outputs return to reset values immediately; the partial frame is discarded.

Decomposition:
- Shared package seg7_pkg:
  - 16 segment-pattern localparams (SEG_0..SEG_F) and SEG_BLANK=7'b1111111, also used by the display encoder.
  - State encoding IDLE/SETTLE/HOLD.
  - Helper constant ANODE_NONE=8'hFF.
- One sub-module: seg7_pattern_decoder. Combinational; 7-bit pattern in -> 4-bit value, blank, err out. Unit-testable on its own and reusable by the bench.

Test Plan:
- Reset check: hold reset=0 with arbitrary inputs -> digit_value=0, digit_blank=FF, digit_err=0, no pulses. Release reset -> outputs unchanged until the first stable digit.
- Single digit: Anode=8'b11111011, LED_out=0010010 held 10 cycles (SETTLE=4) -> digit_value[11:8]=4'h2 exactly 7 cycles after the input change, digit_blank[2]=0, no frame_valid.
- Full frame: scan digits 0..7 showing 0..7, 20 cycles each -> digit_value=32'h76543210, one frame_valid pulse after the digit-7 write, seen cleared. A second identical scan gives a second pulse.
- Glitch rejection: LED_out toggles 0000001/1001111 every 2 cycles on anode 0 -> no write. Then hold 1001111 -> digit0=1.
- Error paths:
  - Anode=8'b11110011 held -> one anode_err pulse and no write.
  - LED_out=1110111 on digit 5 -> digit_err[5]=1, value 0.
  - All-off pattern -> digit_blank[5]=1.
- Mid-frame reset: capture digits 0..3, assert reset for 1 cycle, then scan the full frame -> frame_valid fires only after all 8 post-reset captures.
